// File: rtl/uart_tx_core_pkg.sv
// UART transmitter shared definitions.
// TX state encodings and parity-type constants shared with the RX path.
package uart_tx_core_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_core_if.sv
// UART transmitter request/line interface.
// master drives the byte request, slave returns line and busy.
interface uart_tx_core_if #(
   parameter int DATA_WIDTH = 8
);

   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  DATA_VALID;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic                  TX_OUT;
   logic                  busy;

   modport master (
      output P_DATA,
      output DATA_VALID,
      output PAR_EN,
      output PAR_TYP,
      input  TX_OUT,
      input  busy
   );

   modport slave (
      input  P_DATA,
      input  DATA_VALID,
      input  PAR_EN,
      input  PAR_TYP,
      output TX_OUT,
      output busy
   );

endinterface

// File: rtl/uart_tx_serializer.sv
// UART TX data shift register and bit counter.
// ser_bit is the next data bit to emit; ser_done once all bits emitted.
module uart_tx_serializer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  load,
   input  logic                  shift_en,
   input  logic [DATA_WIDTH-1:0] data,
   output logic                  ser_bit,
   output logic                  ser_done
);

   localparam int CW = $clog2(DATA_WIDTH) + 1;

   logic [DATA_WIDTH-1:0] shift_q;
   logic [CW-1:0]         bit_cnt;

   // Load the byte on accept, shift out LSB first and count emitted bits.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         shift_q <= '0;
         bit_cnt <= '0;
      end else if (load) begin
         shift_q <= data;
         bit_cnt <= '0;
      end else if (shift_en && !ser_done) begin
         shift_q <= {1'b0, shift_q[DATA_WIDTH-1:1]};
         bit_cnt <= bit_cnt + 1'b1;
      end
   end

   assign ser_bit  = shift_q[0];
   assign ser_done = (bit_cnt == CW'(DATA_WIDTH));

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start, LSB-first data, optional parity, stop.
// One bit per CLK; TX_OUT and busy are flop outputs.
module uart_tx_core
   import uart_tx_core_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input logic       CLK,
   input logic       RST,
   uart_tx_core_if.slave tx
);

   logic [2:0] state;
   logic       tx_q;
   logic       busy_q;
   logic       par_en_q;
   logic       par_bit;
   logic       load;
   logic       shift_en;
   logic       ser_bit;
   logic       ser_done;

   // Accept and serializer shift strobes decoded from the current state.
   always_comb begin
      load     = (state == ST_IDLE) && tx.DATA_VALID;
      shift_en = (state == ST_START) ||
                 ((state == ST_DATA) && !ser_done);
   end

   uart_tx_serializer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ser (
      .CLK      (CLK),
      .RST      (RST),
      .load     (load),
      .shift_en (shift_en),
      .data     (tx.P_DATA),
      .ser_bit  (ser_bit),
      .ser_done (ser_done)
   );

   // Frame FSM; each edge registers the line value of the state entered.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= ST_IDLE;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         par_en_q <= 1'b0;
         par_bit  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (tx.DATA_VALID) begin
                  state    <= ST_START;
                  tx_q     <= 1'b0;
                  busy_q   <= 1'b1;
                  par_en_q <= tx.PAR_EN;
                  par_bit  <= (^tx.P_DATA) ^ (tx.PAR_TYP == PAR_ODD);
               end else begin
                  tx_q   <= 1'b1;
                  busy_q <= 1'b0;
               end
            end
            ST_START: begin
               state <= ST_DATA;
               tx_q  <= ser_bit;
            end
            ST_DATA: begin
               if (!ser_done) begin
                  tx_q <= ser_bit;
               end else if (par_en_q) begin
                  state <= ST_PARITY;
                  tx_q  <= par_bit;
               end else begin
                  state <= ST_STOP;
                  tx_q  <= 1'b1;
               end
            end
            ST_PARITY: begin
               state <= ST_STOP;
               tx_q  <= 1'b1;
            end
            ST_STOP: begin
               state  <= ST_IDLE;
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
            end
            default: begin
               state  <= ST_IDLE;
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign tx.TX_OUT = tx_q;
   assign tx.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Testbench for uart_tx_core.
// Expected {busy,tx} per cycle queued at stimulus, compared at negedge.
module tb_uart_tx_core;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   logic [1:0] exp_q[$];

   uart_tx_core_if #(.DATA_WIDTH(8)) bus ();

   uart_tx_core #(
      .DATA_WIDTH (8)
   ) dut (
      .CLK (clk),
      .RST (rst_n),
      .tx  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [1:0] obs,
                      input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed={busy,tx}=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic push_frame(input logic [7:0] d, input logic pen,
                             input logic ptyp);
      logic [7:0] v;
      v = d;
      exp_q.push_back(2'b10);
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, v[i]});
      if (pen) exp_q.push_back({1'b1, (^v) ^ ptyp});
      exp_q.push_back(2'b11);
   endtask

   task automatic push_idle();
      exp_q.push_back(2'b01);
   endtask

   task automatic drain(input string tag, input int inj_at,
                        input int drop_at);
      int i;
      logic [1:0] e;
      i = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (i == inj_at) begin
            bus.DATA_VALID = 1'b1;
            bus.P_DATA     = 8'h3C;
            bus.PAR_EN     = 1'b1;
         end
         if (i == inj_at + 1) bus.DATA_VALID = 1'b0;
         if (i == drop_at) bus.DATA_VALID = 1'b0;
         chk($sformatf("%s[%0d]", tag, i), {bus.busy, bus.TX_OUT}, e);
         @(negedge clk);
         i++;
      end
   endtask

   task automatic start(input logic [7:0] d, input logic pen,
                        input logic ptyp);
      bus.P_DATA     = d;
      bus.PAR_EN     = pen;
      bus.PAR_TYP    = ptyp;
      bus.DATA_VALID = 1'b1;
      @(negedge clk);
      bus.DATA_VALID = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      bus.P_DATA     = '0;
      bus.DATA_VALID = 1'b0;
      bus.PAR_EN     = 1'b0;
      bus.PAR_TYP    = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset", {bus.busy, bus.TX_OUT}, 2'b01);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", {bus.busy, bus.TX_OUT}, 2'b01);

      // 1: 0xA5, no parity
      push_frame(8'hA5, 1'b0, 1'b0); push_idle();
      start(8'hA5, 1'b0, 1'b0);
      drain("a5_nopar", -10, -10);

      // 2: 0xA5 even then odd parity
      push_frame(8'hA5, 1'b1, 1'b0); push_idle();
      start(8'hA5, 1'b1, 1'b0);
      drain("a5_even", -10, -10);
      push_frame(8'hA5, 1'b1, 1'b1); push_idle();
      start(8'hA5, 1'b1, 1'b1);
      drain("a5_odd", -10, -10);

      // 3: 0x00 odd, 0xFF even
      push_frame(8'h00, 1'b1, 1'b1); push_idle();
      start(8'h00, 1'b1, 1'b1);
      drain("00_odd", -10, -10);
      push_frame(8'hFF, 1'b1, 1'b0); push_idle();
      start(8'hFF, 1'b1, 1'b0);
      drain("ff_even", -10, -10);

      // 4: request during a frame is ignored
      push_frame(8'h55, 1'b0, 1'b0); push_idle(); push_idle();
      start(8'h55, 1'b0, 1'b0);
      drain("busy_ignore", 3, -10);

      // 5: DATA_VALID held high, back-to-back frames
      push_frame(8'h12, 1'b0, 1'b0); push_idle();
      push_frame(8'h34, 1'b0, 1'b0); push_idle();
      bus.P_DATA     = 8'h12;
      bus.PAR_EN     = 1'b0;
      bus.PAR_TYP    = 1'b0;
      bus.DATA_VALID = 1'b1;
      @(negedge clk);
      bus.P_DATA = 8'h34;
      drain("b2b", -10, 12);

      // 6: async reset during data bit 3
      start(8'hC3, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) @(negedge clk);
      chk("pre_reset_bit3", {bus.busy, bus.TX_OUT}, 2'b10);
      rst_n = 1'b0;
      #1;
      chk("async_reset", {bus.busy, bus.TX_OUT}, 2'b01);
      @(negedge clk);
      rst_n = 1'b1;
      push_idle(); push_idle(); push_idle();
      drain("post_reset_idle", -10, -10);
      push_frame(8'h96, 1'b1, 1'b1); push_idle();
      start(8'h96, 1'b1, 1'b1);
      drain("post_reset_frame", -10, -10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
